// File: rtl/matrix_scan_driver_if.sv
// Frame transfer channel between a frame producer (column decoders) and the
// matrix scan driver: a full frame of row bits moves on valid & ready.
interface matrix_scan_driver_if #(
  parameter int COLUMNS = 5,
  parameter int ROWS    = 7
);
  logic [COLUMNS*ROWS-1:0] frame_data;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/matrix_scan_driver.sv
// Time-multiplexed 5x7 LED matrix scan driver. Frames arrive over a
// valid/ready channel into a shadow buffer and are promoted to the active
// buffer only at frame boundaries, so the display never shows a torn frame.
// Each column slot opens with BLANK_CYCLES of all-off output to avoid ghosting.
module matrix_scan_driver #(
  parameter int COLUMNS        = 5,
  parameter int ROWS           = 7,
  parameter int DIV            = 25000,
  parameter int BLANK_CYCLES   = 2,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  matrix_scan_driver_if.slave        frm,
  output logic                       frame_start,
  output logic [COLUMNS-1:0]         matrix_col,
  output logic [ROWS-1:0]            matrix_row
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int FW = COLUMNS * ROWS;

  localparam logic [PW-1:0]      P_LAST  = PW'(DIV - 1);
  localparam logic [CW-1:0]      C_LAST  = CW'(COLUMNS - 1);
  localparam logic [PW-1:0]      P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [COLUMNS-1:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic               COL_ON  = (COL_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  logic [PW-1:0]      p_q, p_d;
  logic [CW-1:0]      c_q, c_d;
  logic               en_q, en_d;
  logic [FW-1:0]      active_q, active_d;
  logic [FW-1:0]      shadow_q, shadow_d;
  logic               shadow_empty_q, shadow_empty_d;
  logic               frame_start_q, frame_start_d;
  logic [COLUMNS-1:0] col_q, col_d;
  logic [ROWS-1:0]    row_q, row_d;

  logic boundary;
  logic transfer;

  // Boundary: last slot of the last column, or the first enabled cycle after
  // the scan was held. Transfer: producer offers and the shadow is free.
  assign boundary = enable & (~en_q | ((p_q == P_LAST) & (c_q == C_LAST)));
  assign transfer = frm.frame_valid & shadow_empty_q;

  // Slot counter and column index; held at the frame start while disabled.
  always_comb begin
    p_d  = p_q;
    c_d  = c_q;
    en_d = enable;
    if (!enable) begin
      p_d = '0;
      c_d = '0;
    end else if (p_q == P_LAST) begin
      p_d = '0;
      c_d = (c_q == C_LAST) ? '0 : c_q + CW'(1);
    end else begin
      p_d = p_q + PW'(1);
    end
  end

  // Double buffer: promote shadow at a boundary, accept a new frame when free.
  // A transfer only happens with the shadow empty, so it never collides with
  // a promotion; a frame landing on the boundary cycle waits a whole frame.
  always_comb begin
    active_d       = active_q;
    shadow_d       = shadow_q;
    shadow_empty_d = shadow_empty_q;
    frame_start_d  = boundary;
    if (boundary && !shadow_empty_q) begin
      active_d       = shadow_q;
      shadow_empty_d = 1'b1;
    end
    if (transfer) begin
      shadow_d       = frm.frame_data;
      shadow_empty_d = 1'b0;
    end
  end

  // Output decode from the current (c,p): blank during the slot lead-in or
  // when disabled, otherwise exactly one column strobe with its row bits.
  always_comb begin
    col_d = COL_OFF;
    row_d = '0;
    if (enable && (p_q >= P_BLANK)) begin
      for (int i = 0; i < COLUMNS; i++) begin
        if (c_q == CW'(i)) begin
          col_d[i] = COL_ON;
          row_d    = active_q[i*ROWS +: ROWS];
        end
      end
    end
  end

  // State and registered outputs; reset blanks the matrix immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_q            <= '0;
      c_q            <= '0;
      en_q           <= 1'b0;
      active_q       <= '0;
      shadow_q       <= '0;
      shadow_empty_q <= 1'b1;
      frame_start_q  <= 1'b0;
      col_q          <= COL_OFF;
      row_q          <= '0;
    end else begin
      p_q            <= p_d;
      c_q            <= c_d;
      en_q           <= en_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      shadow_empty_q <= shadow_empty_d;
      frame_start_q  <= frame_start_d;
      col_q          <= col_d;
      row_q          <= row_d;
    end
  end

  assign frm.frame_ready = shadow_empty_q;
  assign frame_start     = frame_start_q;
  assign matrix_col      = col_q;
  assign matrix_row      = row_q;

endmodule
